// File: rtl/prbs_checker_multi.sv
// prbs_checker_multi: N-lane self-seeding PRBS checker. Each lane seeds from its own
// recovered data, verifies, locks, then counts checked bits and errors over a fixed window.
module prbs_checker_multi #(
    parameter int N_LANES     = 1,
    parameter int PRBS_ORDER  = 7,
    parameter int LOCK_COUNT  = 32,
    parameter int UNLOCK_ERRS = 8,
    parameter int WINDOW_LEN  = 1000,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_LANES-1:0]           data_in,
    input  logic [N_LANES-1:0]           data_vld,
    input  logic                         clear,
    output logic [N_LANES-1:0]           locked,
    output logic [N_LANES*CNT_WIDTH-1:0] bit_cnt,
    output logic [N_LANES*CNT_WIDTH-1:0] err_cnt,
    output logic [N_LANES-1:0]           lane_done,
    output logic                         done
);

    localparam int TAP = (PRBS_ORDER == 7)  ? 6  :
                         (PRBS_ORDER == 15) ? 14 :
                         (PRBS_ORDER == 31) ? 28 : 1;

    localparam int SEED_W  = $clog2(PRBS_ORDER + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int BLK_W   = $clog2(UNLOCK_ERRS + 1);

    localparam logic [SEED_W-1:0]  SEED_LAST  = SEED_W'(PRBS_ORDER - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [BLK_W-1:0]   BLK_LIMIT  = BLK_W'(UNLOCK_ERRS);
    localparam logic [5:0]         BLK_LAST   = 6'd63;
    localparam logic [63:0]        WIN64      = 64'(WINDOW_LEN);

    if (PRBS_ORDER != 7 && PRBS_ORDER != 15 && PRBS_ORDER != 31) begin : g_bad_order
        $error("prbs_checker_multi: PRBS_ORDER must be 7, 15 or 31");
    end

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [PRBS_ORDER-1:0] shift_in(input logic [PRBS_ORDER-1:0] v,
                                                       input logic                  b);
        return {v[PRBS_ORDER-2:0], b};
    endfunction

    logic [N_LANES-1:0] w_ldone_nxt;
    logic               r_done;

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        state_t                r_state;
        logic [PRBS_ORDER-1:0] r_lfsr;
        logic [SEED_W-1:0]     r_seed_cnt;
        logic [MATCH_W-1:0]    r_match_cnt;
        logic [5:0]            r_blk_bits;
        logic [BLK_W-1:0]      r_blk_errs;
        logic [CNT_WIDTH-1:0]  r_bit_cnt;
        logic [CNT_WIDTH-1:0]  r_err_cnt;
        logic                  r_locked;
        logic                  r_ldone;

        logic                  w_vld;
        logic                  w_din;
        logic                  w_pred;
        logic                  w_mis;
        logic                  w_cnt_en;
        logic                  w_hit;
        logic [CNT_WIDTH-1:0]  w_bit_inc;
        logic [BLK_W-1:0]      w_blk_errs_inc;

        assign w_vld          = data_vld[g];
        assign w_din          = data_in[g];
        assign w_pred         = r_lfsr[PRBS_ORDER-1] ^ r_lfsr[TAP-1];
        assign w_mis          = w_din ^ w_pred;
        // A clear cycle swallows the strobe for counting but the FSM still tracks it
        assign w_cnt_en       = w_vld && !clear && (r_state == ST_LOCKED) && !r_ldone;
        assign w_bit_inc      = sat_inc(r_bit_cnt);
        assign w_hit          = (64'(w_bit_inc) == WIN64);
        assign w_blk_errs_inc = r_blk_errs + BLK_W'(w_mis);
        assign w_ldone_nxt[g] = !clear && (r_ldone || (w_cnt_en && w_hit));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state     <= ST_SEED;
                r_lfsr      <= '0;
                r_seed_cnt  <= '0;
                r_match_cnt <= '0;
                r_blk_bits  <= '0;
                r_blk_errs  <= '0;
                r_bit_cnt   <= '0;
                r_err_cnt   <= '0;
                r_locked    <= 1'b0;
                r_ldone     <= 1'b0;
            end else begin
                r_ldone <= w_ldone_nxt[g];
                if (clear) begin
                    r_bit_cnt  <= '0;
                    r_err_cnt  <= '0;
                    r_blk_bits <= '0;
                    r_blk_errs <= '0;
                end else if (w_cnt_en) begin
                    r_bit_cnt <= w_bit_inc;
                    if (w_mis) begin
                        r_err_cnt <= sat_inc(r_err_cnt);
                    end
                end

                if (w_vld) begin
                    unique case (r_state)
                        ST_SEED: begin
                            r_lfsr <= shift_in(r_lfsr, w_din);
                            if (r_seed_cnt == SEED_LAST) begin
                                r_state     <= ST_VERIFY;
                                r_seed_cnt  <= '0;
                                r_match_cnt <= '0;
                            end else begin
                                r_seed_cnt <= r_seed_cnt + 1'b1;
                            end
                        end
                        ST_VERIFY: begin
                            // Free-run on the prediction so one bad bit cannot re-seed the LFSR
                            r_lfsr <= shift_in(r_lfsr, w_pred);
                            if (w_mis) begin
                                r_state    <= ST_SEED;
                                r_seed_cnt <= '0;
                            end else if (r_match_cnt == MATCH_LAST) begin
                                r_state    <= ST_LOCKED;
                                r_locked   <= 1'b1;
                                r_blk_bits <= '0;
                                r_blk_errs <= '0;
                            end else begin
                                r_match_cnt <= r_match_cnt + 1'b1;
                            end
                        end
                        ST_LOCKED: begin
                            r_lfsr <= shift_in(r_lfsr, w_pred);
                            if (!clear) begin
                                if (w_blk_errs_inc == BLK_LIMIT) begin
                                    r_state    <= ST_SEED;
                                    r_seed_cnt <= '0;
                                    r_locked   <= 1'b0;
                                end else if (r_blk_bits == BLK_LAST) begin
                                    r_blk_bits <= '0;
                                    r_blk_errs <= '0;
                                end else begin
                                    r_blk_bits <= r_blk_bits + 1'b1;
                                    r_blk_errs <= w_blk_errs_inc;
                                end
                            end
                        end
                        default: begin
                            r_state    <= ST_SEED;
                            r_seed_cnt <= '0;
                            r_locked   <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign locked[g]                              = r_locked;
        assign lane_done[g]                           = r_ldone;
        assign bit_cnt[g*CNT_WIDTH +: CNT_WIDTH]      = r_bit_cnt;
        assign err_cnt[g*CNT_WIDTH +: CNT_WIDTH]      = r_err_cnt;
    end

    // done is registered from the same next-state as lane_done so both rise together
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= &w_ldone_nxt;
        end
    end

    assign done = r_done;

endmodule

// File: tb/tb_prbs_checker_multi.sv
// Bench for prbs_checker_multi: three instances (PRBS7 x1, PRBS15 x4, PRBS31 x1 with 4-bit
// counters) driven by generated PRBS streams and compared every cycle to a sequence-level model.
`timescale 1ns/1ps
module tb_prbs_checker_multi;
    localparam int M_SEED = 0;
    localparam int M_VER  = 1;
    localparam int M_LOCK = 2;
    localparam int LOCKN  = 32;
    localparam int UNLK   = 8;
    localparam int WIN    = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        a_rst, a_clr, a_done;
    logic [0:0]  a_din, a_vld, a_locked, a_ldone;
    logic [31:0] a_bit, a_err;

    logic         b_rst, b_clr, b_done;
    logic [3:0]   b_din, b_vld, b_locked, b_ldone;
    logic [127:0] b_bit, b_err;

    logic       c_rst, c_clr, c_done;
    logic [0:0] c_din, c_vld, c_locked, c_ldone;
    logic [3:0] c_bit, c_err;

    prbs_checker_multi #(.N_LANES(1), .PRBS_ORDER(7)) dut_a (
        .clk(clk), .rst(a_rst), .data_in(a_din), .data_vld(a_vld), .clear(a_clr),
        .locked(a_locked), .bit_cnt(a_bit), .err_cnt(a_err), .lane_done(a_ldone), .done(a_done));

    prbs_checker_multi #(.N_LANES(4), .PRBS_ORDER(15)) dut_b (
        .clk(clk), .rst(b_rst), .data_in(b_din), .data_vld(b_vld), .clear(b_clr),
        .locked(b_locked), .bit_cnt(b_bit), .err_cnt(b_err), .lane_done(b_ldone), .done(b_done));

    prbs_checker_multi #(.N_LANES(1), .PRBS_ORDER(31), .CNT_WIDTH(4)) dut_c (
        .clk(clk), .rst(c_rst), .data_in(c_din), .data_vld(c_vld), .clear(c_clr),
        .locked(c_locked), .bit_cnt(c_bit), .err_cnt(c_err), .lane_done(c_ldone), .done(c_done));

    // Model lanes: 0 = dut_a, 1..4 = dut_b lanes 0..3, 5 = dut_c
    int     ord_m[6], tap_m[6];
    longint max_m[6];
    int     mode[6], seedc[6], matchc[6], blkb[6], blke[6];
    longint mbit[6], merr[6];
    bit     mld[6];
    bit     rbuf[6][64];
    int     rn[6];
    bit     gbuf[6][64];
    int     gn[6];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit hist(input int m, input int back);
        return rbuf[m][(rn[m] - back) & 63];
    endfunction

    task automatic push(input int m, input bit b);
        rbuf[m][rn[m] & 63] = b;
        rn[m]++;
    endtask

    task automatic gen_bit(input int m, output bit b);
        if (gn[m] == 0) b = 1'b1;
        else if (gn[m] < ord_m[m]) b = 1'($urandom_range(0, 1));
        else b = gbuf[m][(gn[m] - ord_m[m]) & 63] ^ gbuf[m][(gn[m] - tap_m[m]) & 63];
        gbuf[m][gn[m] & 63] = b;
        gn[m]++;
    endtask

    task automatic model_clear(input int m);
        mbit[m] = 0; merr[m] = 0; mld[m] = 1'b0; blkb[m] = 0; blke[m] = 0;
    endtask

    task automatic model_reset(input int m);
        model_clear(m);
        mode[m] = M_SEED; seedc[m] = 0; matchc[m] = 0;
    endtask

    task automatic model_step(input int m, input bit d, input bit clr);
        bit p, e;
        p = hist(m, ord_m[m]) ^ hist(m, tap_m[m]);
        if (mode[m] == M_SEED) begin
            push(m, d);
            seedc[m]++;
            if (seedc[m] == ord_m[m]) begin mode[m] = M_VER; matchc[m] = 0; end
        end else if (mode[m] == M_VER) begin
            push(m, p);
            if (d != p) begin
                mode[m] = M_SEED; seedc[m] = 0;
            end else begin
                matchc[m]++;
                if (matchc[m] == LOCKN) begin mode[m] = M_LOCK; blkb[m] = 0; blke[m] = 0; end
            end
        end else begin
            push(m, p);
            e = d ^ p;
            if (!clr) begin
                if (!mld[m]) begin
                    if (mbit[m] < max_m[m]) mbit[m]++;
                    if (e && merr[m] < max_m[m]) merr[m]++;
                    if (mbit[m] == WIN) mld[m] = 1'b1;
                end
                blkb[m]++;
                blke[m] += int'(e);
                if (blke[m] >= UNLK) begin mode[m] = M_SEED; seedc[m] = 0; end
                else if (blkb[m] == 64) begin blkb[m] = 0; blke[m] = 0; end
            end
        end
    endtask

    task automatic model_cycle();
        if (a_rst) model_reset(0);
        else begin
            if (a_clr) model_clear(0);
            if (a_vld[0]) model_step(0, a_din[0], a_clr);
        end
        for (int l = 0; l < 4; l++) begin
            if (b_rst) model_reset(l + 1);
            else begin
                if (b_clr) model_clear(l + 1);
                if (b_vld[l]) model_step(l + 1, b_din[l], b_clr);
            end
        end
        if (c_rst) model_reset(5);
        else begin
            if (c_clr) model_clear(5);
            if (c_vld[0]) model_step(5, c_din[0], c_clr);
        end
    endtask

    task automatic check_all();
        chk("a.locked", 64'(a_locked), 64'(mode[0] == M_LOCK));
        chk("a.bit_cnt", 64'(a_bit), 64'(mbit[0]));
        chk("a.err_cnt", 64'(a_err), 64'(merr[0]));
        chk("a.lane_done", 64'(a_ldone), 64'(mld[0]));
        chk("a.done", 64'(a_done), 64'(mld[0]));
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("b.locked[%0d]", l), 64'(b_locked[l]), 64'(mode[l+1] == M_LOCK));
            chk($sformatf("b.bit_cnt[%0d]", l), 64'(b_bit[l*32 +: 32]), 64'(mbit[l+1]));
            chk($sformatf("b.err_cnt[%0d]", l), 64'(b_err[l*32 +: 32]), 64'(merr[l+1]));
            chk($sformatf("b.lane_done[%0d]", l), 64'(b_ldone[l]), 64'(mld[l+1]));
        end
        chk("b.done", 64'(b_done), 64'(mld[1] & mld[2] & mld[3] & mld[4]));
        chk("c.locked", 64'(c_locked), 64'(mode[5] == M_LOCK));
        chk("c.bit_cnt", 64'(c_bit), 64'(mbit[5]));
        chk("c.err_cnt", 64'(c_err), 64'(merr[5]));
        chk("c.done", 64'(c_done), 64'(mld[5]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_cycle();
        check_all();
    endtask

    task automatic a_feed(input bit inv);
        bit g;
        gen_bit(0, g);
        a_vld[0] = 1'b1;
        a_din[0] = g ^ inv;
        tick();
        a_vld[0] = 1'b0;
    endtask

    task automatic c_feed(input bit inv);
        bit g;
        gen_bit(5, g);
        c_vld[0] = 1'b1;
        c_din[0] = g ^ inv;
        tick();
        c_vld[0] = 1'b0;
    endtask

    int duty[4];
    int rise[4];
    int done_cyc, last_rise;
    bit g, inv;

    initial begin
        for (int m = 0; m < 6; m++) begin
            gn[m] = 0; rn[m] = 0;
            max_m[m] = 64'h0000_0000_FFFF_FFFF;
            model_reset(m);
        end
        ord_m[0] = 7;  tap_m[0] = 6;
        for (int m = 1; m < 5; m++) begin ord_m[m] = 15; tap_m[m] = 14; end
        ord_m[5] = 31; tap_m[5] = 28; max_m[5] = 15;

        a_rst = 1'b1; a_clr = 1'b0; a_din = '0; a_vld = '0;
        b_rst = 1'b1; b_clr = 1'b0; b_din = '0; b_vld = '0;
        c_rst = 1'b1; c_clr = 1'b0; c_din = '0; c_vld = '0;
        tick();
        tick();
        chk("rst.a_locked", 64'(a_locked), 64'd0);
        chk("rst.a_bit", 64'(a_bit), 64'd0);
        chk("rst.b_done", 64'(b_done), 64'd0);
        chk("rst.c_err", 64'(c_err), 64'd0);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

        // Clean PRBS7: lock after 7+32, window of 1000, freeze afterwards
        for (int i = 0; i < 38; i++) a_feed(1'b0);
        chk("t1.locked_before_39", 64'(a_locked), 64'd0);
        a_feed(1'b0);
        chk("t1.locked_at_39", 64'(a_locked), 64'd1);
        for (int i = 0; i < 999; i++) a_feed(1'b0);
        chk("t1.done_at_999", 64'(a_done), 64'd0);
        a_feed(1'b0);
        chk("t1.done", 64'(a_done), 64'd1);
        chk("t1.bit_cnt", 64'(a_bit), 64'd1000);
        chk("t1.err_cnt", 64'(a_err), 64'd0);
        for (int i = 0; i < 20; i++) a_feed(1'b0);
        chk("t1.frozen_bit_cnt", 64'(a_bit), 64'd1000);
        chk("t1.still_locked", 64'(a_locked), 64'd1);

        // Isolated errors, then a burst of 8 inside one block forces relock
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("t2.cleared_done", 64'(a_done), 64'd0);
        for (int k = 0; k < 200; k++) a_feed(k == 10 || k == 80 || k == 150);
        chk("t2.err3", 64'(a_err), 64'd3);
        chk("t2.locked_after_3", 64'(a_locked), 64'd1);
        for (int k = 0; k < 8; k++) a_feed(1'b1);
        chk("t2.unlocked", 64'(a_locked), 64'd0);
        chk("t2.err11", 64'(a_err), 64'd11);
        chk("t2.bit208", 64'(a_bit), 64'd208);
        for (int i = 0; i < 38; i++) a_feed(1'b0);
        chk("t2.not_yet_relocked", 64'(a_locked), 64'd0);
        chk("t2.bit_hold", 64'(a_bit), 64'd208);
        a_feed(1'b0);
        chk("t2.relocked", 64'(a_locked), 64'd1);
        for (int i = 0; i < 10; i++) a_feed(1'b0);
        chk("t2.bit_resume", 64'(a_bit), 64'd218);

        // Mismatch on the 20th verify bit sends the lane back to seeding
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        for (int i = 0; i < 26; i++) a_feed(1'b0);
        a_feed(1'b1);
        chk("t3.locked_after_bad", 64'(a_locked), 64'd0);
        for (int i = 0; i < 38; i++) a_feed(1'b0);
        chk("t3.locked_at_38", 64'(a_locked), 64'd0);
        a_feed(1'b0);
        chk("t3.locked_at_39", 64'(a_locked), 64'd1);

        // clear with a simultaneous strobe, then rst mid-window
        for (int i = 0; i < 300; i++) a_feed(1'b0);
        chk("t5.bit300", 64'(a_bit), 64'd300);
        gen_bit(0, g);
        a_clr = 1'b1; a_vld[0] = 1'b1; a_din[0] = g;
        tick();
        a_clr = 1'b0; a_vld[0] = 1'b0;
        chk("t5.clr_bit", 64'(a_bit), 64'd0);
        chk("t5.clr_err", 64'(a_err), 64'd0);
        chk("t5.clr_locked", 64'(a_locked), 64'd1);
        for (int i = 0; i < 5; i++) a_feed(1'b0);
        chk("t5.bit5", 64'(a_bit), 64'd5);
        gen_bit(0, g);
        a_rst = 1'b1; a_vld[0] = 1'b1; a_din[0] = g;
        tick();
        a_rst = 1'b0; a_vld[0] = 1'b0;
        chk("t5.rst_locked", 64'(a_locked), 64'd0);
        chk("t5.rst_bit", 64'(a_bit), 64'd0);
        chk("t5.rst_done", 64'(a_done), 64'd0);
        for (int i = 0; i < 38; i++) a_feed(1'b0);
        chk("t5.relock_early", 64'(a_locked), 64'd0);
        a_feed(1'b0);
        chk("t5.relock", 64'(a_locked), 64'd1);

        // Four PRBS15 lanes, random strobe duty, lane 2 error every 100 locked bits
        duty[0] = 100;
        duty[1] = int'($urandom_range(25, 100));
        duty[2] = int'($urandom_range(25, 100));
        duty[3] = 25;
        for (int l = 0; l < 4; l++) rise[l] = -1;
        done_cyc = -1;
        for (int cyc = 0; cyc < 12000 && !b_done; cyc++) begin
            for (int l = 0; l < 4; l++) begin
                b_vld[l] = (int'($urandom_range(1, 100)) <= duty[l]);
                b_din[l] = 1'b0;
                if (b_vld[l]) begin
                    gen_bit(l + 1, g);
                    inv = (l == 2) && (mode[3] == M_LOCK) && !mld[3] && ((mbit[3] + 1) % 100 == 0);
                    b_din[l] = g ^ inv;
                end
            end
            tick();
            for (int l = 0; l < 4; l++) if (b_ldone[l] && rise[l] < 0) rise[l] = cyc;
            if (b_done && done_cyc < 0) done_cyc = cyc;
        end
        b_vld = '0;
        chk("t4.done", 64'(b_done), 64'd1);
        last_rise = rise[0];
        for (int l = 1; l < 4; l++) if (rise[l] > last_rise) last_rise = rise[l];
        chk("t4.done_with_slowest", 64'(done_cyc), 64'(last_rise));
        for (int l = 0; l < 4; l++) chk($sformatf("t4.bit[%0d]", l), 64'(b_bit[l*32 +: 32]), 64'd1000);
        chk("t4.err_lane2", 64'(b_err[64 +: 32]), 64'd10);
        chk("t4.err_lane0", 64'(b_err[0 +: 32]), 64'd0);

        // PRBS31 with 4-bit counters: saturation
        for (int i = 0; i < 62; i++) c_feed(1'b0);
        chk("t6.locked_early", 64'(c_locked), 64'd0);
        c_feed(1'b0);
        chk("t6.locked", 64'(c_locked), 64'd1);
        for (int k = 0; k < 200; k++) c_feed(k % 10 == 5);
        chk("t6.err_sat", 64'(c_err), 64'd15);
        chk("t6.bit_sat", 64'(c_bit), 64'd15);
        chk("t6.still_locked", 64'(c_locked), 64'd1);
        chk("t6.no_done", 64'(c_ldone), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
